// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, default sizes and sample type for the FIR frame arbiter
package fir_pkg;
  localparam int FRAME_LEN_D = 1024;
  localparam int TAPS_D = 32;
  localparam int DW_D = 16;
  localparam int CW_D = 11;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;
  typedef logic signed [DW_D-1:0] sample_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the channel not served last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_ch,
  output logic [1:0] gnt
);
  // one-hot pick, favouring the channel opposite last_ch on a tie
  always_comb gnt = (req == 2'b11) ? (last_ch ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/fir_frame_arbiter.sv
// fir_frame_arbiter: time-shares one streaming FIR between two channels, one flushed frame at a time
module fir_frame_arbiter
  import fir_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_D,
  parameter int TAPS = TAPS_D,
  parameter int DW = DW_D,
  parameter int CW = CW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  output logic [1:0]    grant,
  output logic          fir_clear,
  output logic [DW-1:0] fir_din,
  output logic          fir_din_valid,
  input  logic [DW-1:0] fir_res,
  input  logic          fir_res_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_ch,
  output logic          out_last,
  output logic          busy,
  output logic          err_stray
);
  localparam logic [CW-1:0] TOTAL = CW'(FRAME_LEN + TAPS - 1);
  localparam logic [CW-1:0] LAST_S = CW'(FRAME_LEN - 1);
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, arb_gnt;
  logic [CW-1:0] scnt_q, scnt_d, rcnt_q, rcnt_d;
  logic last_ch_q, last_ch_d;
  logic [DW-1:0] out_data_q, out_data_d, in_data;
  logic out_valid_q, out_valid_d, out_ch_q, out_ch_d, out_last_q, out_last_d;
  logic err_stray_q, err_stray_d;
  logic in_valid, accept, res_acc;
  rr_arb2 u_arb (.req(req), .last_ch(last_ch_q), .gnt(arb_gnt));
  // sample path: the granted source passes straight through to the FIR; flush injects zeros
  always_comb begin
    in_valid = grant_q[1] ? in1_valid : in0_valid;
    in_data = grant_q[1] ? in1_data : in0_data;
    accept = (state_q == FEED) && in_valid;
    in0_ready = (state_q == FEED) && grant_q[0];
    in1_ready = (state_q == FEED) && grant_q[1];
    fir_clear = state_q == CLEAR;
    fir_din_valid = accept || (state_q == FLUSH);
    fir_din = accept ? in_data : '0;
    res_acc = fir_res_valid && (state_q != IDLE) && (rcnt_q != TOTAL);
  end
  // frame sequencing, result capture and stray-result detection
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    scnt_d = scnt_q;
    rcnt_d = res_acc ? rcnt_q + 1'b1 : rcnt_q;
    last_ch_d = last_ch_q;
    out_valid_d = res_acc;
    out_data_d = res_acc ? fir_res : '0;
    out_ch_d = res_acc && grant_q[1];
    out_last_d = res_acc && (rcnt_q == TOTAL - 1'b1);
    err_stray_d = err_stray_q || (fir_res_valid && state_q == IDLE);
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        rcnt_d = '0;
        grant_d = arb_gnt;
        state_d = (|req) ? CLEAR : IDLE;
      end
      CLEAR: begin
        scnt_d = '0;
        last_ch_d = grant_q[1];
        state_d = FEED;
      end
      FEED: begin
        scnt_d = accept ? scnt_q + 1'b1 : scnt_q;
        state_d = (accept && scnt_q == LAST_S) ? FLUSH : FEED;
      end
      FLUSH: begin
        scnt_d = scnt_q + 1'b1;
        state_d = (scnt_q != TOTAL - 1'b1) ? FLUSH : (rcnt_q == TOTAL) ? IDLE : DRAIN;
        grant_d = (scnt_q == TOTAL - 1'b1 && rcnt_q == TOTAL) ? 2'b00 : grant_q;
      end
      DRAIN: begin
        state_d = (rcnt_q == TOTAL) ? IDLE : DRAIN;
        grant_d = (rcnt_q == TOTAL) ? 2'b00 : grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      scnt_q <= '0;
      rcnt_q <= '0;
      last_ch_q <= 1'b1;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q <= 1'b0;
      out_last_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      scnt_q <= scnt_d;
      rcnt_q <= rcnt_d;
      last_ch_q <= last_ch_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q <= out_ch_d;
      out_last_q <= out_last_d;
      err_stray_q <= err_stray_d;
    end
  end
  assign grant = grant_q;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch = out_ch_q;
  assign out_last = out_last_q;
  assign busy = state_q != IDLE;
  assign err_stray = err_stray_q;
endmodule

// File: tb/tb_fir_frame_arbiter.sv
// tb_fir_frame_arbiter: directed frame scenarios against an identity FIR model with two-cycle latency
module tb_fir_frame_arbiter;
  logic clk = 1'b0, rst = 1'b1, stray = 1'b0;
  logic [1:0] req = 2'b00;
  logic [15:0] in0_data = '0, in1_data = '0;
  logic in0_valid = 1'b0, in1_valid = 1'b0;
  logic in0_ready, in1_ready, fir_clear, fir_din_valid, fir_res_valid;
  logic out_valid, out_ch, out_last, busy, err_stray;
  logic [1:0] grant;
  logic [15:0] fir_din, fir_res, out_data;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [15:0] p1 = '0, p2 = '0;
  int ncmp = 0, nerr = 0;
  int n_clear, n_acc, n_flush, n_zero, n_out, n_last, last_idx, n_bad_data, n_bad_din;
  int n_bad_ch, n_other, n_mirror, timeout;
  logic [1:0] g_first, g_after;
  logic b_after;

  fir_frame_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .grant(grant), .fir_clear(fir_clear), .fir_din(fir_din), .fir_din_valid(fir_din_valid),
    .fir_res(fir_res), .fir_res_valid(fir_res_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  // identity filter: every shifted-in sample comes back as a result two cycles later
  always @(posedge clk) begin
    v1 <= rst ? 1'b0 : fir_din_valid;
    v2 <= rst ? 1'b0 : v1;
    p1 <= fir_din;
    p2 <= p1;
  end
  assign fir_res_valid = v2 | stray;
  assign fir_res = v2 ? p2 : 16'h7777;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int ch, input bit toggle, input int drop_at, input int stop_at);
    int d = 1, cyc = 0;
    bit v = 1'b1, saw = 1'b0, first = 1'b1;
    logic acc = 1'b0, rdy, oth;
    n_clear = 0; n_acc = 0; n_flush = 0; n_zero = 0; n_out = 0; n_last = 0; last_idx = 0;
    n_bad_data = 0; n_bad_din = 0; n_bad_ch = 0; n_other = 0; n_mirror = 0; timeout = 0;
    g_first = 2'bxx; g_after = 2'bxx; b_after = 1'bx;
    forever begin
      @(posedge clk); #1;
      if (acc) d++;
      v = toggle ? ~v : 1'b1;
      if (n_acc >= drop_at) req = 2'b00;
      if (ch == 0) begin
        in0_data = 16'(d); in0_valid = v; in1_data = 16'h5A5A; in1_valid = 1'b1;
      end else begin
        in1_data = 16'(d); in1_valid = v; in0_data = 16'h5A5A; in0_valid = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (first) begin g_first = grant; first = 1'b0; end
      if (saw) begin g_after = grant; b_after = busy; break; end
      rdy = (ch == 0) ? in0_ready : in1_ready;
      oth = (ch == 0) ? in1_ready : in0_ready;
      acc = rdy & v;
      if (fir_clear) n_clear++;
      if (oth) n_other++;
      if (rdy && fir_din_valid !== v) n_mirror++;
      if (acc) begin
        n_acc++;
        if (fir_din !== 16'(d)) n_bad_din++;
      end else if (fir_din_valid) begin
        n_flush++;
        if (fir_din === 16'h0) n_zero++;
      end
      if (out_valid) begin
        n_out++;
        if (out_data !== (n_out <= 1024 ? 16'(n_out) : 16'h0)) n_bad_data++;
        if (out_ch !== ch[0]) n_bad_ch++;
        if (out_last) begin n_last++; last_idx = n_out; saw = 1'b1; end
      end
      if (n_acc >= stop_at) break;
      if (cyc > 5000) begin timeout = 1; break; end
    end
  endtask

  task automatic chk_full(input string tag, input logic [1:0] g);
    chk({tag, ".grant"}, g_first, g);
    chk({tag, ".clear"}, n_clear, 1);
    chk({tag, ".acc"}, n_acc, 1024);
    chk({tag, ".din"}, n_bad_din, 0);
    chk({tag, ".flush"}, n_flush, 31);
    chk({tag, ".zeros"}, n_zero, 31);
    chk({tag, ".nout"}, n_out, 1055);
    chk({tag, ".last_idx"}, last_idx, 1055);
    chk({tag, ".nlast"}, n_last, 1);
    chk({tag, ".data"}, n_bad_data, 0);
    chk({tag, ".ch"}, n_bad_ch, 0);
    chk({tag, ".other_rdy"}, n_other, 0);
    chk({tag, ".grant_after"}, g_after, 2'b00);
    chk({tag, ".busy_after"}, b_after, 1'b0);
    chk({tag, ".timeout"}, timeout, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.grant", grant, 2'b00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.rdy0", in0_ready, 1'b0);
    chk("rst.rdy1", in1_ready, 1'b0);
    chk("rst.clear", fir_clear, 1'b0);
    chk("rst.din_valid", fir_din_valid, 1'b0);
    chk("rst.din", fir_din, 16'h0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_data", out_data, 16'h0);
    chk("rst.out_last", out_last, 1'b0);
    chk("rst.out_ch", out_ch, 1'b0);
    chk("rst.err", err_stray, 1'b0);
    rst = 1'b0;
    req = 2'b11;
    run_frame(0, 1'b0, 1 << 30, 1 << 30);
    chk_full("tie1", 2'b01);
    run_frame(1, 1'b0, 0, 1 << 30);
    chk_full("tie2", 2'b10);
    req = 2'b01;
    run_frame(0, 1'b0, 0, 1 << 30);
    chk_full("ch0", 2'b01);
    req = 2'b01;
    run_frame(0, 1'b1, 0, 1 << 30);
    chk_full("toggle", 2'b01);
    chk("toggle.mirror", n_mirror, 0);
    req = 2'b01;
    run_frame(0, 1'b0, 0, 500);
    chk("abort.acc", n_acc, 500);
    chk("abort.nlast", n_last, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.grant", grant, 2'b00);
    chk("abort.busy", busy, 1'b0);
    chk("abort.out_last", out_last, 1'b0);
    chk("abort.out_valid", out_valid, 1'b0);
    chk("abort.rdy0", in0_ready, 1'b0);
    rst = 1'b0;
    req = 2'b10;
    run_frame(1, 1'b0, 300, 1 << 30);
    chk_full("drop", 2'b10);
    chk("drop.err", err_stray, 1'b0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray.out_valid", out_valid, 1'b0);
    chk("stray.err", err_stray, 1'b1);
    repeat (5) @(negedge clk);
    chk("stray.hold", err_stray, 1'b1);
    chk("stray.busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stray.cleared", err_stray, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fir_frame_arbiter.md
Name: fir_frame_arbiter

Overview:
- Frame-level arbiter and sequencer that time-shares one 32-tap streaming FIR datapath between two sample requesters.
- For each granted frame it:
  - clears the FIR delay line;
  - forwards FRAME_LEN input samples;
  - appends TAPS-1 zero samples to flush the filter;
  - routes the FRAME_LEN+TAPS-1 returned results to the output, tagged with the channel.
- Sits between the sample sources and the FIR core; the FIR core is unmodified.

Parameters:
- FRAME_LEN, 1024, input samples per frame (≥2)
- TAPS, 32, filter length; flush length is TAPS-1
- DW, 16, sample and result width (signed)
- CW, 11, counter width; must satisfy 2^CW > FRAME_LEN+TAPS-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-channel frame request; sampled only in IDLE
- in0_data  in  DW  channel 0 sample
- in0_valid  in  1  channel 0 sample valid
- in0_ready  out  1  channel 0 sample accepted when valid&ready
- in1_data  in  DW  channel 1 sample
- in1_valid  in  1  channel 1 sample valid
- in1_ready  out  1  channel 1 sample accepted when valid&ready
- grant  out  2  one-hot owner of the FIR; 00 when idle
- fir_clear  out  1  one-cycle pulse, zeroes the FIR delay line
- fir_din  out  DW  sample to FIR
- fir_din_valid  out  1  FIR shift enable
- fir_res  in  DW  FIR result
- fir_res_valid  in  1  FIR result valid
- out_data  out  DW  registered result
- out_valid  out  1  result valid
- out_ch  out  1  channel of out_data
- out_last  out  1  final result of frame
- busy  out  1  state != IDLE
- err_stray  out  1  sticky: result arrived while IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - outputs: state IDLE; grant=00, ready=0, fir_clear=0, fir_din=0, fir_din_valid=0, out_*=0, busy=0, err_stray=0.
  - internals: counters=0, last_ch=1, so ch0 wins the first tie.
  - Mid-frame reset abandons the frame immediately; no out_last is issued.
- States: IDLE → CLEAR → FEED → FLUSH → DRAIN → IDLE.
- IDLE:
  - If req≠00, pick the channel: the sole requester, or !last_ch if both request (round-robin).
  - Next cycle: grant set, fir_clear=1, state CLEAR.
- CLEAR (1 cycle):
  - fir_din_valid=0.
  - Result counter rcnt=0, sample counter scnt=0; last_ch←granted channel.
- FEED:
  - inX_ready=1 for the granted channel only; the other ready stays 0.
  - On accept: fir_din=data, fir_din_valid=1 in the same cycle (combinational pass-through), scnt++.
  - Source stall: valid=0 → fir_din_valid=0.
  - The accept with scnt==FRAME_LEN-1 moves to FLUSH.
- FLUSH:
  - ready=0; fir_din=0, fir_din_valid=1 every cycle for exactly TAPS-1 cycles, no stall.
  - Then go to DRAIN.
- DRAIN: wait until rcnt==FRAME_LEN+TAPS-1, then IDLE with grant=00 the same edge.
  - If the final result arrives during FLUSH, go directly from FLUSH to IDLE after the flush completes.
- Results, in any non-IDLE state:
  - fir_res_valid → next cycle out_valid=1, out_data=fir_res, out_ch=granted channel, rcnt++.
  - out_last=1 on result number FRAME_LEN+TAPS-1.
  - Results beyond that count are dropped.
- Result latency: 1 cycle from fir_res_valid to out_valid.
- Result arriving in IDLE: dropped; err_stray set until rst.
- req changes during a frame: ignored; the frame is committed once granted.
- req held high by the winner at IDLE re-entry: the other channel wins if it also requests; otherwise the same channel is re-granted with 1 idle cycle between frames.
- No arithmetic on samples: widths pass through, signed. Counters wrap never (bounded by parameters).

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE, CLEAR, FEED, FLUSH, DRAIN);
  - FRAME_LEN/TAPS/DW defaults;
  - sample typedef (signed DW).
- Sub-module rr_arb2: 2-input round-robin picker with a last_ch pointer, used in IDLE.
- Counters are inline.

Test Plan:
- Reset then req=01, in0 streams 1..1024 with continuous valid:
  - fir_clear pulses once;
  - 1024 pass-through samples, then 31 zeros with fir_din_valid=1;
  - model FIR returns 1055 results → out_last on the 1055th, out_ch=0, grant=00 next cycle.
- req=11 held across two frames:
  - first grant=01, second grant=10;
  - exactly one idle cycle between frames; second frame out_ch=1.
- Channel 0 valid toggled 50% during FEED:
  - fir_din_valid mirrors accepts; scnt still stops at 1024;
  - in1_ready stays 0 throughout.
- rst asserted at sample 500 of a frame:
  - next cycle grant=00, busy=0, no out_last;
  - next req=10 grants ch1 cleanly with fir_clear.
- fir_res_valid pulsed while IDLE:
  - no out_valid; err_stray=1 and holds until rst.
- req=10 deasserted mid-FEED:
  - frame completes all 1024+31 samples and the 1055-result drain unaffected.
